// File: rtl/uart_cfg_seq_if.sv
// Bundle of the configuration-sequencer signals: request/config inputs, register-file
// ports, UART activity and sequence status. The sequencer connects through 'master'.
interface uart_cfg_seq_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  start;
    logic                  cfg_enable;
    logic [2:0]            cfg_mode;
    logic [15:0]           cfg_rate;
    logic                  cfg_clr_err;

    logic                  wr_en;
    logic [2:0]            wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    logic [2:0]            rd_addr_a;
    logic [DATA_WIDTH-1:0] rd_data_a;
    logic                  rd_valid_a;

    logic                  uart_busy;
    logic                  update_ok;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        input  start, cfg_enable, cfg_mode, cfg_rate, cfg_clr_err,
        input  rd_data_a, rd_valid_a, uart_busy,
        output wr_en, wr_addr, wr_data, rd_addr_a,
        output update_ok, busy, done, error
    );

    modport slave (
        output start, cfg_enable, cfg_mode, cfg_rate, cfg_clr_err,
        output rd_data_a, rd_valid_a, uart_busy,
        input  wr_en, wr_addr, wr_data, rd_addr_a,
        input  update_ok, busy, done, error
    );
endinterface

// File: rtl/uart_cfg_seq.sv
// UART configuration sequencer: disables the UART, programs the shadow baud rate, waits
// for the line to go quiet, commits the baud rate, reads it back and re-enables.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting for start; captures cfg_* on start
// ST_CLR       | write 0x0002 to STATUS (W1C clears error bit)
// ST_DIS       | write 0 to CTRL, UART disabled
// ST_BAUD      | write captured rate to shadow BAUD
// ST_WAIT_IDLE | wait for IDLE_CYCLES quiet cycles, bounded by TIMEOUT
// ST_COMMIT    | pulse update_ok, shadow BAUD becomes active
// ST_VERIFY    | read BAUD on port A and compare with captured rate
// ST_ENABLE    | write {mode, enable} to CTRL
// ST_DONE      | done pulse, success
// ST_FAIL      | done pulse, error set, CTRL left at 0
module uart_cfg_seq #(
    parameter int DATA_WIDTH  = 16,
    parameter int IDLE_CYCLES = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_cfg_seq_if.master bus
);

    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_BAUD   = 3'd1;
    localparam logic [2:0] ADDR_STATUS = 3'd2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLR,
        ST_DIS,
        ST_BAUD,
        ST_WAIT_IDLE,
        ST_COMMIT,
        ST_VERIFY,
        ST_ENABLE,
        ST_DONE,
        ST_FAIL
    } state_t;

    state_t              state_q, state_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [15:0]         rate_q, rate_d;
    logic [2:0]          mode_q, mode_d;
    logic                enable_q, enable_d;
    logic                error_q, error_d;

    logic                idle_met;
    logic                timed_out;
    logic                rate_match;

    logic                  wr_en;
    logic [2:0]            wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [2:0]            rd_addr_a;
    logic                  update_ok;
    logic                  done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idle_cnt_q <= '0;
            to_cnt_q   <= '0;
            rate_q     <= '0;
            mode_q     <= '0;
            enable_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            to_cnt_q   <= to_cnt_d;
            rate_q     <= rate_d;
            mode_q     <= mode_d;
            enable_q   <= enable_d;
            error_q    <= error_d;
        end
    end

    assign idle_met   = !bus.uart_busy && (idle_cnt_q == IDLE_W'(IDLE_CYCLES - 1));
    assign timed_out  = (to_cnt_q == TO_W'(TIMEOUT - 1));
    assign rate_match = bus.rd_valid_a && (bus.rd_data_a == DATA_WIDTH'(rate_q));

    // Counters only run in ST_WAIT_IDLE; holding them at zero elsewhere clears them on entry.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = '0;
        to_cnt_d   = '0;
        rate_d     = rate_q;
        mode_d     = mode_q;
        enable_d   = enable_q;
        error_d    = error_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    rate_d   = bus.cfg_rate;
                    mode_d   = bus.cfg_mode;
                    enable_d = bus.cfg_enable;
                    error_d  = 1'b0;
                    state_d  = bus.cfg_clr_err ? ST_CLR : ST_DIS;
                end
            end
            ST_CLR:  state_d = ST_DIS;
            ST_DIS:  state_d = ST_BAUD;
            ST_BAUD: state_d = ST_WAIT_IDLE;
            ST_WAIT_IDLE: begin
                idle_cnt_d = bus.uart_busy ? '0 : idle_cnt_q + IDLE_W'(1);
                to_cnt_d   = to_cnt_q + TO_W'(1);
                if (idle_met) begin
                    state_d = ST_COMMIT;
                end else if (timed_out) begin
                    state_d = ST_FAIL;
                end
            end
            ST_COMMIT: state_d = ST_VERIFY;
            ST_VERIFY: state_d = rate_match ? ST_ENABLE : ST_FAIL;
            ST_ENABLE: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            ST_FAIL:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (state_d == ST_FAIL) begin
            error_d = 1'b1;
        end
    end

    // Moore outputs: every strobe and bus value is a pure decode of state_q.
    always_comb begin
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr_a = '0;
        update_ok = 1'b0;
        done      = 1'b0;

        case (state_q)
            ST_CLR: begin
                wr_en   = 1'b1;
                wr_addr = ADDR_STATUS;
                wr_data = DATA_WIDTH'(2);
            end
            ST_DIS: begin
                wr_en   = 1'b1;
                wr_addr = ADDR_CTRL;
            end
            ST_BAUD: begin
                wr_en   = 1'b1;
                wr_addr = ADDR_BAUD;
                wr_data = DATA_WIDTH'(rate_q);
            end
            ST_COMMIT: update_ok = 1'b1;
            ST_VERIFY: rd_addr_a = ADDR_BAUD;
            ST_ENABLE: begin
                wr_en   = 1'b1;
                wr_addr = ADDR_CTRL;
                wr_data = DATA_WIDTH'({mode_q, enable_q});
            end
            ST_DONE: done = 1'b1;
            ST_FAIL: done = 1'b1;
            default: ;
        endcase
    end

    assign bus.wr_en     = wr_en;
    assign bus.wr_addr   = wr_addr;
    assign bus.wr_data   = wr_data;
    assign bus.rd_addr_a = rd_addr_a;
    assign bus.update_ok = update_ok;
    assign bus.done      = done;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.error     = error_q;

endmodule

// File: tb/tb_uart_cfg_seq.sv
// Randomised bench for uart_cfg_seq: each transaction's expected register writes, commit
// and done pulses are predicted from the sequence rules and checked by a separate monitor.
module tb_uart_cfg_seq;

    localparam int IDLE_CYCLES = 4;
    localparam int TIMEOUT     = 1024;

    localparam logic [1:0] K_WR   = 2'd0;
    localparam logic [1:0] K_UPD  = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;

    typedef struct {
        int          cyc;
        logic [1:0]  kind;
        logic [2:0]  addr;
        logic [15:0] data;
        logic        err;
    } ev_t;

    logic        clk;
    logic        rst_n;
    int          cyc;
    int          n_chk;
    int          n_pass;
    bit          mon_en;
    ev_t         exp_q[$];

    logic [15:0] cur_rate;
    logic        bad_data;
    logic        bad_valid;

    uart_cfg_seq_if #(.DATA_WIDTH(16)) ifc ();

    uart_cfg_seq #(
        .DATA_WIDTH (16),
        .IDLE_CYCLES(IDLE_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc.master)
    );

    // Register-file stub: BAUD reads back the rate this transaction programmed.
    assign ifc.rd_data_a  = (ifc.rd_addr_a == 3'd1) ? (bad_data ? (cur_rate ^ 16'h0F0F) : cur_rate) : 16'h0000;
    assign ifc.rd_valid_a = !bad_valid;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [63:0] pack(input int c, input logic [1:0] k, input logic [2:0] a,
                                         input logic [15:0] d, input logic e);
        return {10'd0, c[31:0], k, a, e, d};
    endfunction

    task automatic push_ev(input int cut, input int c, input logic [1:0] k, input logic [2:0] a,
                           input logic [15:0] d, input logic e);
        ev_t ev;
        if (cut > 0 && c > cut) return;
        ev.cyc = c; ev.kind = k; ev.addr = a; ev.data = d; ev.err = e;
        exp_q.push_back(ev);
    endtask

    always @(negedge clk) begin
        logic [63:0] act;
        ev_t         e;
        if (mon_en) begin
            if (!ifc.wr_en) chk("idle_wr_bus", {45'd0, ifc.wr_addr, ifc.wr_data}, 64'd0);
            chk("wr_upd_exclusive", {63'd0, ifc.wr_en & ifc.update_ok}, 64'd0);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                chk("missed_event_cycle", 64'(cyc), 64'(e.cyc));
            end
            if (ifc.wr_en || ifc.update_ok || ifc.done) begin
                act = pack(cyc, ifc.done ? K_DONE : (ifc.update_ok ? K_UPD : K_WR),
                           ifc.wr_addr, ifc.wr_data, ifc.done ? ifc.error : 1'b0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", act, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event", act, pack(e.cyc, e.kind, e.addr, e.data, e.err));
                end
            end
        end
    end

    // Called at #1 after a posedge with the DUT idle. bad_mode: 0 good, 1 wrong data, 2 invalid.
    // cut_off > 0 asserts reset cut_off cycles after the start cycle.
    task automatic run_txn(input bit clr, input logic [15:0] rate, input logic [2:0] mode,
                           input bit en, input int busy_len, input int bad_mode,
                           input bit junk, input int cut_off);
        int t0, w, c, d, cut, last;
        bit exp_err;
        t0  = cyc;
        w   = t0 + 3 + int'(clr);
        cut = (cut_off > 0) ? t0 + cut_off : 0;

        ifc.start       = 1'b1;
        ifc.cfg_clr_err = clr;
        ifc.cfg_rate    = rate;
        ifc.cfg_mode    = mode;
        ifc.cfg_enable  = en;
        cur_rate        = rate;
        bad_data        = (bad_mode == 1);
        bad_valid       = (bad_mode == 2);

        if (clr) push_ev(cut, t0 + 1, K_WR, 3'd2, 16'h0002, 1'b0);
        push_ev(cut, t0 + 1 + int'(clr), K_WR, 3'd0, 16'h0000, 1'b0);
        push_ev(cut, t0 + 2 + int'(clr), K_WR, 3'd1, rate, 1'b0);
        // Commit once IDLE_CYCLES quiet cycles have been seen inside the TIMEOUT window.
        c = w + busy_len + IDLE_CYCLES - 1;
        if (c <= w + TIMEOUT - 1) begin
            push_ev(cut, c + 1, K_UPD, 3'd0, 16'h0000, 1'b0);
            if (bad_mode == 0) begin
                push_ev(cut, c + 3, K_WR, 3'd0, {12'd0, mode, en}, 1'b0);
                d = c + 4; exp_err = 1'b0;
            end else begin
                d = c + 3; exp_err = 1'b1;
            end
        end else begin
            d = w + TIMEOUT; exp_err = 1'b1;
        end
        push_ev(cut, d, K_DONE, 3'd0, 16'h0000, exp_err);

        last = (cut > 0) ? cut : d + 1;
        while (cyc < last) begin
            @(posedge clk); #1;
            ifc.start       = junk && (cyc <= d) && ($urandom_range(0, 2) == 0);
            ifc.cfg_rate    = 16'($urandom);
            ifc.cfg_mode    = 3'($urandom);
            ifc.cfg_enable  = 1'($urandom);
            ifc.cfg_clr_err = 1'($urandom);
            if (cyc < w) ifc.uart_busy = 1'($urandom_range(0, 1));
            else         ifc.uart_busy = (cyc < w + busy_len);
        end

        if (cut > 0) begin
            rst_n         = 1'b0;
            ifc.start     = 1'b0;
            ifc.uart_busy = 1'b0;
            @(posedge clk); #1;
            chk("busy_after_reset", {63'd0, ifc.busy}, 64'd0);
            chk("no_update_after_reset", {63'd0, ifc.update_ok}, 64'd0);
            @(posedge clk); #1;
            rst_n = 1'b1;
        end else begin
            ifc.start = 1'b0;
            chk("busy_end", {63'd0, ifc.busy}, 64'd0);
            chk("error_sticky", {63'd0, ifc.error}, {63'd0, exp_err});
        end
    endtask

    initial begin
        int bl, bm;
        cyc = 0; n_chk = 0; n_pass = 0; mon_en = 1'b0;
        rst_n = 1'b0;
        ifc.start = 1'b0; ifc.cfg_enable = 1'b0; ifc.cfg_mode = 3'd0;
        ifc.cfg_rate = 16'd0; ifc.cfg_clr_err = 1'b0; ifc.uart_busy = 1'b0;
        cur_rate = 16'd0; bad_data = 1'b0; bad_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",      {63'd0, ifc.busy},      64'd0);
        chk("rst_done",      {63'd0, ifc.done},      64'd0);
        chk("rst_error",     {63'd0, ifc.error},     64'd0);
        chk("rst_wr_en",     {63'd0, ifc.wr_en},     64'd0);
        chk("rst_update_ok", {63'd0, ifc.update_ok}, 64'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        run_txn(1'b0, 16'h4B00, 3'd3, 1'b1, 0, 0, 1'b0, 0);
        run_txn(1'b1, 16'h2580, 3'd5, 1'b1, 0, 0, 1'b0, 0);
        run_txn(1'b0, 16'h1234, 3'd2, 1'b0, 10, 0, 1'b0, 0);
        run_txn(1'b0, 16'h0960, 3'd1, 1'b1, 5000, 0, 1'b0, 0);
        run_txn(1'b0, 16'hC350, 3'd6, 1'b1, 0, 1, 1'b0, 0);
        run_txn(1'b0, 16'hC350, 3'd6, 1'b1, 0, 0, 1'b0, 0);
        run_txn(1'b0, 16'h00FF, 3'd7, 1'b1, 3, 2, 1'b0, 0);
        run_txn(1'b0, 16'h7777, 3'd4, 1'b1, 8, 0, 1'b1, 0);
        run_txn(1'b0, 16'hBEEF, 3'd2, 1'b1, 0, 0, 1'b1, 5);
        run_txn(1'b1, 16'h1C20, 3'd3, 1'b1, 2, 0, 1'b0, 0);

        for (int i = 0; i < 25; i++) begin
            bl = ($urandom_range(0, 9) == 0) ? 1500 : int'($urandom_range(0, 12));
            bm = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_txn(1'($urandom), 16'($urandom), 3'($urandom), 1'($urandom), bl, bm,
                    ($urandom_range(0, 2) == 0), 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
